// File: rtl/cache_control_pkg.sv
// Shared types for the LC-3b two-way set-associative cache controller.
// Optional performance counters are enabled with CACHE_PERF_CNT_EN.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } lc3b_cache_state;

    typedef logic        lc3b_way;
    typedef logic [15:0] lc3b_perf_count;

    localparam lc3b_perf_count PERF_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cache_control_perf_counter.sv
// Saturating 16-bit event counter; only instantiated when CACHE_PERF_CNT_EN is defined.
module cache_perf_counter
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           inc,
    output lc3b_perf_count count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (inc && (count != PERF_COUNT_MAX))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/cache_control.sv
// Control FSM for the LC-3b 2-way write-back/write-allocate cache.
// Hit/miss performance counters are built only when CACHE_PERF_CNT_EN is defined.
module cache_control
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [1:0]     mem_byte_enable,
    output logic           mem_resp,
    input  logic           hit0,
    input  logic           hit1,
    input  logic           valid0,
    input  logic           valid1,
    input  logic           dirty0,
    input  logic           dirty1,
    input  logic           lru_out,
    output logic           pmem_read,
    output logic           pmem_write,
    input  logic           pmem_resp,
    output logic           data_write0,
    output logic           data_write1,
    output logic           tag_write0,
    output logic           tag_write1,
    output logic           valid_write0,
    output logic           valid_write1,
    output logic           dirty_write0,
    output logic           dirty_write1,
    output logic           dirty_in,
    output logic           lru_write,
    output logic           lru_in,
    output logic           way_sel,
    output logic           datain_sel,
    output logic [1:0]     membytemux_sel,
    output logic           pmem_addr_sel,
    output lc3b_perf_count hit_count,
    output lc3b_perf_count miss_count
);

    lc3b_cache_state state, next_state;
    lc3b_way         victim, victim_q, hit_way;
    logic            req, hit, victim_dirty, leave_idle;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = hit0 ? 1'b0 : 1'b1;
    // Fill an empty way before evicting anything; LRU only decides between two valid ways.
    assign victim       = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru_out);
    assign victim_dirty = victim ? (dirty1 & valid1) : (dirty0 & valid0);
    assign leave_idle   = (state == IDLE) && (next_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state <= next_state;
            if (leave_idle)
                victim_q <= victim;
        end
    end

    always_comb begin
        next_state     = state;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        data_write0    = 1'b0;
        data_write1    = 1'b0;
        tag_write0     = 1'b0;
        tag_write1     = 1'b0;
        valid_write0   = 1'b0;
        valid_write1   = 1'b0;
        dirty_write0   = 1'b0;
        dirty_write1   = 1'b0;
        dirty_in       = 1'b0;
        lru_write      = 1'b0;
        lru_in         = 1'b0;
        way_sel        = 1'b0;
        datain_sel     = 1'b0;
        membytemux_sel = 2'b00;
        pmem_addr_sel  = 1'b0;
        // Outputs stay quiet while reset is held, even though the hit path is combinational.
        if (reset_n) begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp  = 1'b1;
                        way_sel   = hit_way;
                        lru_write = 1'b1;
                        lru_in    = ~hit_way;
                        if (mem_write) begin
                            data_write0    = ~hit_way;
                            data_write1    = hit_way;
                            dirty_write0   = ~hit_way;
                            dirty_write1   = hit_way;
                            dirty_in       = 1'b1;
                            datain_sel     = 1'b1;
                            membytemux_sel = mem_byte_enable;
                        end
                    end else if (req) begin
                        next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = victim_q;
                    if (pmem_resp)
                        next_state = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_write0  = ~victim_q;
                        data_write1  = victim_q;
                        tag_write0   = ~victim_q;
                        tag_write1   = victim_q;
                        valid_write0 = ~victim_q;
                        valid_write1 = victim_q;
                        dirty_write0 = ~victim_q;
                        dirty_write1 = victim_q;
                        next_state   = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    cache_perf_counter u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (mem_resp),
        .count   (hit_count)
    );

    cache_perf_counter u_miss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (leave_idle),
        .count   (miss_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: table of IDLE hit vectors plus miss/reset sequences.
module tb_cache_control;

`ifdef CACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic        hit0 = 1'b0, hit1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
    logic        dirty0 = 1'b0, dirty1 = 1'b0, lru_out = 1'b0;
    logic        pmem_resp, model_resp = 1'b0, spur_resp = 1'b0;
    logic        mem_resp, pmem_read, pmem_write;
    logic        data_write0, data_write1, tag_write0, tag_write1;
    logic        valid_write0, valid_write1, dirty_write0, dirty_write1;
    logic        dirty_in, lru_write, lru_in, way_sel, datain_sel, pmem_addr_sel;
    logic [1:0]  membytemux_sel;
    logic [15:0] hit_count, miss_count;

    int passed = 0, total = 0;
    int lat = 3;
    int pcnt = 0;

    assign pmem_resp = model_resp | spur_resp;

    always #5 clk = ~clk;

    cache_control dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru_out(lru_out),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .data_write0(data_write0), .data_write1(data_write1),
        .tag_write0(tag_write0), .tag_write1(tag_write1),
        .valid_write0(valid_write0), .valid_write1(valid_write1),
        .dirty_write0(dirty_write0), .dirty_write1(dirty_write1),
        .dirty_in(dirty_in), .lru_write(lru_write), .lru_in(lru_in),
        .way_sel(way_sel), .datain_sel(datain_sel), .membytemux_sel(membytemux_sel),
        .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count), .miss_count(miss_count)
    );

    // {resp rd wr asel}_{dw0 dw1 tw0 tw1}_{vw0 vw1 dyw0 dyw1}_{din lw li ws}_{ds mb1 mb0}
    logic [18:0] outs;
    assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel,
                   data_write0, data_write1, tag_write0, tag_write1,
                   valid_write0, valid_write1, dirty_write0, dirty_write1,
                   dirty_in, lru_write, lru_in, way_sel,
                   datain_sel, membytemux_sel};

    // Physical memory: responds in the (lat+1)th cycle of a held strobe.
    always @(negedge clk) begin
        if (model_resp) begin
            model_resp = 1'b0;
            pcnt = (pmem_read | pmem_write) ? 1 : 0;
        end else begin
            if (pmem_read | pmem_write) pcnt++;
            else pcnt = 0;
            if (pcnt == lat + 1) model_resp = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    typedef struct {
        string      name;
        logic       rd, wr;
        logic [1:0] be;
        logic       h0, h1, v0, v1, lru, presp;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic clear_req();
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        hit0 = 1'b0; hit1 = 1'b0; spur_resp = 1'b0;
    endtask

    initial begin
        bit seen, any_resp;
        int n;

        vecs[0] = '{"no_req",      0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 19'b0000_0000_0000_0000_000};
        vecs[1] = '{"rd_hit0",     1, 0, 2'b00, 1, 0, 1, 1, 0, 0, 19'b1000_0000_0000_0110_000};
        vecs[2] = '{"rd_hit1",     1, 0, 2'b00, 0, 1, 1, 1, 1, 0, 19'b1000_0000_0000_0101_000};
        vecs[3] = '{"wr_hit1_b01", 0, 1, 2'b01, 0, 1, 1, 1, 0, 0, 19'b1000_0100_0001_1101_101};
        vecs[4] = '{"wr_hit0_b10", 0, 1, 2'b10, 1, 0, 1, 1, 0, 0, 19'b1000_1000_0010_1110_110};
        vecs[5] = '{"rdwr_hit0",   1, 1, 2'b11, 1, 0, 1, 1, 1, 0, 19'b1000_1000_0010_1110_111};
        vecs[6] = '{"spur_resp",   1, 0, 2'b00, 0, 1, 1, 1, 0, 1, 19'b1000_0000_0000_0101_000};

        // Reset: outputs forced low even with a hitting request present.
        mem_read = 1'b1; hit0 = 1'b1; valid0 = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset_outs", 32'(outs), 32'h0);
        check("reset_hit_count", 32'(hit_count), 32'h0);
        clear_req(); valid0 = 1'b0;
        @(negedge clk); reset_n = 1'b1;

        // Cold read miss, latency 3: ALLOCATE for 4 cycles, fill way0.
        lat = 3;
        @(negedge clk); mem_read = 1'b1;
        #1 check("cold_no_resp", 32'(mem_resp), 32'h0);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (pmem_read) n++;
            if (data_write0) begin
                seen = 1'b1;
                check("cold_fill_outs", 32'(outs), 32'(19'b0100_1010_1010_0000_000));
            end
        end
        check("cold_fill_seen", 32'(seen), 32'h1);
        check("cold_alloc_cycles", 32'(n), 32'd4);
        @(negedge clk); hit0 = 1'b1; valid0 = 1'b1;
        #1 check("cold_hit_resp", 32'(outs), 32'(19'b1000_0000_0000_0110_000));
        @(negedge clk); clear_req();
        #1 check("cold_miss_count", 32'(miss_count), PERF ? 32'd1 : 32'd0);
        check("cold_hit_count", 32'(hit_count), PERF ? 32'd1 : 32'd0);

        // Table of IDLE vectors: combinational response, state stays IDLE.
        foreach (vecs[k]) begin
            @(negedge clk);
            mem_read = vecs[k].rd; mem_write = vecs[k].wr; mem_byte_enable = vecs[k].be;
            hit0 = vecs[k].h0; hit1 = vecs[k].h1; valid0 = vecs[k].v0; valid1 = vecs[k].v1;
            lru_out = vecs[k].lru; spur_resp = vecs[k].presp;
            #1 check(vecs[k].name, 32'(outs), 32'(vecs[k].exp));
        end
        @(negedge clk); clear_req();

        // Dirty eviction: both valid, LRU picks way1 (dirty); LRU changes mid-miss.
        lat = 2;
        valid0 = 1'b1; valid1 = 1'b1; dirty0 = 1'b0; dirty1 = 1'b1; lru_out = 1'b1;
        mem_read = 1'b1;
        #1 check("evict_no_resp", 32'(mem_resp), 32'h0);
        @(negedge clk); lru_out = 1'b0;
        #1 check("evict_wb_outs", 32'(outs), 32'(19'b0011_0000_0000_0001_000));
        seen = 1'b0; any_resp = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (mem_resp) any_resp = 1'b1;
            if (data_write1 || data_write0) begin
                seen = 1'b1;
                check("evict_fill_outs", 32'(outs), 32'(19'b0100_0101_0101_0000_000));
            end
        end
        check("evict_fill_seen", 32'(seen), 32'h1);
        check("evict_no_early_resp", 32'(any_resp), 32'h0);
        @(negedge clk); hit1 = 1'b1; dirty1 = 1'b0;
        #1 check("evict_hit_resp", 32'(outs), 32'(19'b1000_0000_0000_0101_000));
        @(negedge clk); clear_req();

        // Request withdrawn mid-miss: fill completes, no response.
        valid0 = 1'b0; valid1 = 1'b0;
        mem_read = 1'b1;
        @(negedge clk); mem_read = 1'b0;
        seen = 1'b0; any_resp = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (mem_resp) any_resp = 1'b1;
            if (data_write0) seen = 1'b1;
        end
        check("withdraw_fill_seen", 32'(seen), 32'h1);
        @(negedge clk); #1;
        check("withdraw_idle_outs", 32'(outs | {18'b0, any_resp}), 32'h0);

        // Reset pulsed mid-writeback.
        lat = 5;
        valid0 = 1'b1; valid1 = 1'b1; dirty0 = 1'b1; dirty1 = 1'b0; lru_out = 1'b0;
        mem_write = 1'b1; mem_byte_enable = 2'b11;
        @(negedge clk); #1;
        check("rst_wb_entered", 32'(pmem_write), 32'h1);
        @(negedge clk); #2 reset_n = 1'b0;
        #1 check("rst_pmem_write_drop", 32'(outs), 32'h0);
        #1 reset_n = 1'b1; mem_write = 1'b0;
        any_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (outs != 19'b0) any_resp = 1'b1;
        end
        check("rst_quiet_after", 32'(any_resp), 32'h0);
        check("rst_miss_count", 32'(miss_count), 32'h0);
        @(negedge clk); mem_read = 1'b1; hit1 = 1'b1;
        #1 check("rst_idle_hit", 32'(mem_resp), 32'h1);

`ifdef CACHE_PERF_CNT_EN
        // Hold a hit for 65537 cycles (plus the one above): counter pins at FFFF.
        repeat (65537) @(posedge clk);
        @(negedge clk); clear_req();
        #1 check("hit_count_sat", 32'(hit_count), 32'hFFFF);
`else
        repeat (4) @(posedge clk);
        @(negedge clk); clear_req();
        #1 check("hit_count_off", 32'(hit_count), 32'h0);
        check("miss_count_off", 32'(miss_count), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
